// File: rtl/am_tx_scheduler.sv
// am_tx_scheduler
// Two-requester round-robin frame scheduler driving an on-off (AM) carrier gate.
// Each frame is a 2-slot preamble (carrier on), DATA_W data slots sent LSB
// first, then GAP_SLOTS idle slots. A data slot is split into quarters:
// the first quarter is a sync mark, the second carries the bit, and the
// remaining half is off.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active-high
//   enable       allows a new frame to start
//   req_a/b      requester has a word to send
//   data_a/b     requester payload (sampled at the arbitration edge)
//   gnt_a/b      one-cycle pulse: word accepted
//   tx_gate      carrier gate, decoded from registered state only
//   busy         frame in progress
//   cur_src      source of current/last frame (0 = A, 1 = B)
//   frame_done   one-cycle pulse on the final cycle of a frame
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | no frame; arbitrate when enabled and requested
// PREAMBLE | 2 slots, carrier on
// DATA     | DATA_W slots, sync mark + bit + off, LSB first
// GAP      | GAP_SLOTS slots, carrier off; last cycle = frame_done
module am_tx_scheduler #(
    parameter int DATA_W     = 32,
    parameter int BIT_CYCLES = 16,
    parameter int GAP_SLOTS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_b,
    output logic              tx_gate,
    output logic              busy,
    output logic              cur_src,
    output logic              frame_done
);
    localparam int Q  = BIT_CYCLES / 4;
    localparam int SW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [SW-1:0] SLOT_LAST = SW'(BIT_CYCLES - 1);
    localparam logic [SW-1:0] SYNC_END  = SW'(Q);
    localparam logic [SW-1:0] BIT_END   = SW'(2 * Q);
    localparam logic [BW-1:0] PRE_LAST  = BW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     slot_cnt, slot_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              src_nxt, gnt_a_nxt, gnt_b_nxt;
    logic              slot_wrap, arb, winner;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_done = (state == GAP) && slot_wrap && (bit_cnt == GAP_LAST);
    assign busy       = (state != IDLE);

    // Arbitrating on the frame_done cycle lets frames run back to back.
    assign arb = ((state == IDLE) || frame_done) && enable && (req_a || req_b);

    // cur_src doubles as the round-robin last-grant memory; reset to B so A
    // wins the first contention.
    assign winner = (req_a && req_b) ? ~cur_src : req_b;

    always_comb begin
        tx_gate = 1'b0;
        case (state)
            PREAMBLE: tx_gate = 1'b1;
            DATA: begin
                if (slot_cnt < SYNC_END)
                    tx_gate = 1'b1;
                else if (slot_cnt < BIT_END)
                    tx_gate = shreg[0];
            end
            default: tx_gate = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = '0;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        src_nxt   = cur_src;
        gnt_a_nxt = 1'b0;
        gnt_b_nxt = 1'b0;

        if (state != IDLE)
            slot_nxt = slot_wrap ? '0 : slot_cnt + SW'(1);

        case (state)
            IDLE: bit_nxt = '0;
            PREAMBLE: begin
                if (slot_wrap) begin
                    if (bit_cnt == PRE_LAST) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            DATA: begin
                if (slot_wrap) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        state_nxt = GAP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            GAP: begin
                if (slot_wrap) begin
                    if (bit_cnt == GAP_LAST) begin
                        state_nxt = IDLE;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (arb) begin
            state_nxt = PREAMBLE;
            slot_nxt  = '0;
            bit_nxt   = '0;
            src_nxt   = winner;
            shreg_nxt = winner ? data_b : data_a;
            gnt_a_nxt = ~winner;
            gnt_b_nxt = winner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            slot_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            cur_src  <= 1'b1;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot_cnt <= slot_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            cur_src  <= src_nxt;
            gnt_a    <= gnt_a_nxt;
            gnt_b    <= gnt_b_nxt;
        end
    end
endmodule

// File: tb/tb_am_tx_scheduler.sv
// Testbench for am_tx_scheduler with DATA_W=8, BIT_CYCLES=8, GAP_SLOTS=2.
// A frame-position model (cycle index within the frame) predicts every output
// each cycle; directed scenarios add literal expectations on counts and grants.
module tb_am_tx_scheduler;
    localparam int DW    = 8;
    localparam int BC    = 8;
    localparam int GS    = 2;
    localparam int Q     = BC / 4;
    localparam int FRAME = (2 + DW + GS) * BC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic          gnt_a, gnt_b, tx_gate, busy, cur_src, frame_done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    am_tx_scheduler #(.DATA_W(DW), .BIT_CYCLES(BC), .GAP_SLOTS(GS)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
        .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
        .tx_gate(tx_gate), .busy(busy), .cur_src(cur_src),
        .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // Model: m_k is the cycle index within the current frame (-1 = idle).
    int            m_k = -1;
    logic          m_last = 1'b1;
    logic [DW-1:0] m_data = '0;

    function automatic logic exp_tx(input int k, input logic [DW-1:0] d);
        int slot, pos;
        logic b;
        if (k < 0) return 1'b0;
        slot = k / BC;
        pos  = k % BC;
        if (slot < 2) return 1'b1;
        if (slot < 2 + DW) begin
            b = d[slot-2];
            if (pos < Q) return 1'b1;
            if (pos < 2 * Q) return b;
            return 1'b0;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model_and_compare
        logic ra, rb, en, arb, win, done_now;
        logic [DW-1:0] da, db;
        ra = req_a; rb = req_b; en = enable; da = data_a; db = data_b;
        if (rst) begin
            m_k    = -1;
            m_last = 1'b1;
        end else begin
            done_now = (m_k == FRAME - 1);
            arb = ((m_k < 0) || done_now) && en && (ra || rb);
            if (arb) begin
                win    = (ra && rb) ? ~m_last : rb;
                m_last = win;
                m_data = win ? db : da;
                m_k    = 0;
            end else if (m_k >= 0) begin
                m_k = done_now ? -1 : m_k + 1;
            end
        end
        #1;
        chk("tx_gate",    tx_gate,    exp_tx(m_k, m_data));
        chk("busy",       busy,       m_k >= 0);
        chk("frame_done", frame_done, m_k == FRAME - 1);
        chk("gnt_a",      gnt_a,      (m_k == 0) && !m_last);
        chk("gnt_b",      gnt_b,      (m_k == 0) && m_last);
        chk("cur_src",    cur_src,    m_last);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_gnt(output bit got);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            cyc(1);
            if (gnt_a || gnt_b) got = 1;
        end
    endtask

    // Counts cycles and carrier-on cycles from now up to and including frame_done.
    task automatic measure(output int hi, output int len, output bit done);
        hi = 0; len = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            len++;
            if (tx_gate) hi++;
            if (frame_done) done = 1;
            else cyc(1);
        end
    endtask

    initial begin : stimulus
        bit got, done, seen;
        int hi, len;

        cyc(3);
        chk("reset cur_src", cur_src, 1'b1);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;
        enable = 1'b1;

        // Single frame, A, 0xA5: 16 preamble + 4 ones*4 + 4 zeros*2 = 40 on
        data_a = 8'hA5; req_a = 1'b1;
        wait_gnt(got);
        chk("a5 gnt seen", got, 1'b1);
        chk("a5 gnt_a", gnt_a, 1'b1);
        req_a = 1'b0;
        measure(hi, len, done);
        chk("a5 done", done, 1'b1);
        chk_int("a5 frame len", len, 96);
        chk_int("a5 tx high", hi, 40);
        cyc(2);

        // All ones via B alone: 16 + 8*4 = 48 on
        data_b = 8'hFF; req_b = 1'b1;
        wait_gnt(got);
        chk("ff gnt_b", gnt_b, 1'b1);
        chk("ff cur_src", cur_src, 1'b1);
        req_b = 1'b0;
        measure(hi, len, done);
        chk_int("ff frame len", len, 96);
        chk_int("ff tx high", hi, 48);
        cyc(2);

        // All zeros via A: 16 + 8*2 = 32 on
        data_a = 8'h00; req_a = 1'b1;
        wait_gnt(got);
        chk("00 gnt_a", gnt_a, 1'b1);
        req_a = 1'b0;
        measure(hi, len, done);
        chk_int("00 tx high", hi, 32);
        cyc(2);

        // Enable gating
        enable = 1'b0; data_b = 8'h5A; req_b = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (gnt_a || gnt_b || busy) seen = 1;
        end
        chk("gated no grant", seen, 1'b0);
        enable = 1'b1;
        cyc(1);
        chk("enable gnt_b", gnt_b, 1'b1);
        cyc(30);
        enable = 1'b0;
        measure(hi, len, done);
        chk("gated frame done", done, 1'b1);
        chk_int("gated remaining len", len, 66);
        cyc(5);
        chk("gated idle after", busy, 1'b0);
        req_b = 1'b0;
        enable = 1'b1;

        // Reset mid-frame, DATA bit 3, position 1 (sync mark, carrier on)
        data_a = 8'hFF; req_a = 1'b1;
        wait_gnt(got);
        req_a = 1'b0;
        cyc(16 + 3 * BC + 1);
        chk("pre-reset tx on", tx_gate, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst tx_gate", tx_gate, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst frame_done", frame_done, 1'b0);
        data_a = 8'h3C; data_b = 8'hC3;
        req_a = 1'b1; req_b = 1'b1;
        cyc(3);
        chk("rst gnt", gnt_a | gnt_b, 1'b0);
        rst = 1'b0;

        // Contention after reset: A, B, A back to back
        cyc(1);
        chk("rr1 gnt_a", gnt_a, 1'b1);
        chk("rr1 cur_src", cur_src, 1'b0);
        measure(hi, len, done);
        chk_int("rr1 len", len, 96);
        cyc(1);
        chk("rr2 gnt_b", gnt_b, 1'b1);
        chk("rr2 cur_src", cur_src, 1'b1);
        measure(hi, len, done);
        chk_int("rr2 len", len, 96);
        cyc(1);
        chk("rr3 gnt_a", gnt_a, 1'b1);
        chk("rr3 cur_src", cur_src, 1'b0);
        req_a = 1'b0; req_b = 1'b0;
        measure(hi, len, done);
        chk_int("rr3 len", len, 96);
        cyc(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
